// File: rtl/hi_sim_resp_sequencer_if.sv
// Byte-write, frame-control and status bundle between the ARM-side writer and the response sequencer.
// master drives bytes/frame control and observes status; slave is the sequencer itself.
interface hi_sim_resp_sequencer_if;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        abort;
  logic        rx_eof;
  logic [15:0] fdt;
  logic        mod_out;
  logic        busy;
  logic        done;
  logic        fifo_full;
  logic        fifo_empty;

  modport master (
    output wr_data, wr_en, abort, rx_eof, fdt,
    input  mod_out, busy, done, fifo_full, fifo_empty
  );

  modport slave (
    input  wr_data, wr_en, abort, rx_eof, fdt,
    output mod_out, busy, done, fifo_full, fifo_empty
  );
endinterface

// File: rtl/hi_sim_resp_sequencer.sv
// ISO14443A tag response sequencer: buffers bytes, waits fdt after rx_eof, emits SOF/data[/parity]/EOF on mod_out (registered, first SOF cycle fdt+2 after rx_eof).
// No backpressure: writes while full are dropped. Define SIM_SEQ_PARITY_EN to append an odd parity bit to each byte.
module hi_sim_resp_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int BIT_CYCLES = 128
) (
  input  logic                   ck_1356meg,
  input  logic                   reset,
  hi_sim_resp_sequencer_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FDT,
    SOF,
    DATA,
`ifdef SIM_SEQ_PARITY_EN
    PAR,
`endif
    EOF
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     fdt_cnt_q, fdt_cnt_d;
  logic [BW-1:0]   bit_cyc_q, bit_cyc_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            mod_out_q, mod_out_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            fifo_full, fifo_empty;
  logic            wr_acc, pop, byte_end;
  logic [7:0]      rd_data;
  logic            bit_last, first_half, sc, cur_bit, modulated;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign wr_acc     = bus.wr_en && !fifo_full && !bus.abort;
  assign rd_data    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        mem_d[wr_ptr_q] = bus.wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_acc, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Manchester halves: logic 1 modulates the first half, logic 0 the second.
  assign bit_last   = (bit_cyc_q == BW'(BIT_CYCLES - 1));
  assign first_half = !bit_cyc_q[BW-1];
  assign sc         = !bit_cyc_q[3];
  assign modulated  = cur_bit ? (first_half && sc) : (!first_half && sc);

  always_comb begin
    cur_bit = 1'b1;
    if (state_q == DATA) begin
      cur_bit = byte_q[bit_idx_q];
    end
`ifdef SIM_SEQ_PARITY_EN
    if (state_q == PAR) begin
      cur_bit = ~^byte_q;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    fdt_cnt_d = fdt_cnt_q;
    bit_cyc_d = '0;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    mod_out_d = 1'b0;
    pop       = 1'b0;
    byte_end  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rx_eof && !fifo_empty) begin
          fdt_cnt_d = bus.fdt;
          state_d   = WAIT_FDT;
        end
      end
      WAIT_FDT: begin
        if (fdt_cnt_q == '0) begin
          state_d = SOF;
        end else begin
          fdt_cnt_d = fdt_cnt_q - 1'b1;
        end
      end
      SOF: begin
        bit_cyc_d = bit_cyc_q + 1'b1;
        mod_out_d = modulated;
        byte_end  = bit_last;
      end
      DATA: begin
        bit_cyc_d = bit_cyc_q + 1'b1;
        mod_out_d = modulated;
        if (bit_last) begin
          if (bit_idx_q == 3'd7) begin
`ifdef SIM_SEQ_PARITY_EN
            state_d  = PAR;
`else
            byte_end = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef SIM_SEQ_PARITY_EN
      PAR: begin
        bit_cyc_d = bit_cyc_q + 1'b1;
        mod_out_d = modulated;
        byte_end  = bit_last;
      end
`endif
      EOF: begin
        bit_cyc_d = bit_cyc_q + 1'b1;
        if (bit_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bytes appended during transmission extend the frame if they land before the byte boundary.
    if (byte_end) begin
      if (!fifo_empty) begin
        state_d   = DATA;
        pop       = 1'b1;
        byte_d    = rd_data;
        bit_idx_d = '0;
      end else begin
        state_d = EOF;
      end
    end

    if (bus.abort) begin
      state_d   = IDLE;
      pop       = 1'b0;
      mod_out_d = 1'b0;
      fdt_cnt_d = '0;
      bit_cyc_d = '0;
      bit_idx_d = '0;
    end
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      fdt_cnt_q <= '0;
      bit_cyc_q <= '0;
      bit_idx_q <= '0;
      byte_q    <= '0;
      mod_out_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      fdt_cnt_q <= fdt_cnt_d;
      bit_cyc_q <= bit_cyc_d;
      bit_idx_q <= bit_idx_d;
      byte_q    <= byte_d;
      mod_out_q <= mod_out_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign bus.mod_out    = mod_out_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == EOF) && bit_last && !bus.abort;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;

endmodule

// File: tb/tb_hi_sim_resp_sequencer.sv
// Randomized frame bench: expected bit streams and per-cycle Manchester waveforms come from a byte-level model.
module tb_hi_sim_resp_sequencer;
  localparam int DEPTH = 16;
  localparam int BC    = 128;
`ifdef SIM_SEQ_PARITY_EN
  localparam int BPB = 9;
`else
  localparam int BPB = 8;
`endif

  logic ck_1356meg = 1'b0;
  logic reset      = 1'b0;
  int   vectors    = 0;
  int   errors     = 0;

  hi_sim_resp_sequencer_if bus();

  hi_sim_resp_sequencer #(.FIFO_DEPTH(DEPTH), .BIT_CYCLES(BC)) dut (
    .ck_1356meg(ck_1356meg),
    .reset     (reset),
    .bus       (bus.slave)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  task automatic check(input string tag, input logic [BC-1:0] obs, input logic [BC-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ck_1356meg);
    #1;
  endtask

  // One bit time as seen on mod_out: fc/16 subcarrier in the first half for 1, second half for 0.
  function automatic logic [BC-1:0] bit_wave(input bit v);
    logic [BC-1:0] w;
    w = '0;
    for (int c = 0; c < BC; c++)
      w[c] = (((c / 8) % 2) == 0) && (v ? (c < BC / 2) : (c >= BC / 2));
    return w;
  endfunction

  task automatic write_bytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = bytes[i];
      tick;
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [7:0] bytes[$], input int f, input int second_k);
    bit            bits[$];
    logic [BC-1:0] obs;
    int            gap_ones, busy_lo, dones, done_pos;
    bits.push_back(1'b1);
    foreach (bytes[i]) begin
      for (int b = 0; b < 8; b++) bits.push_back(bytes[i][b]);
`ifdef SIM_SEQ_PARITY_EN
      bits.push_back(($countones(bytes[i]) % 2) == 0);
`endif
    end
    gap_ones = 0; busy_lo = 0; dones = 0; done_pos = -1;
    bus.rx_eof = 1'b1;
    bus.fdt    = 16'(f);
    tick;
    bus.rx_eof = 1'b0;
    check({name, "_busy_rise"}, BC'(bus.busy), BC'(1));
    for (int k = 0; k <= f + 1; k++) begin
      if (k > 0) tick;
      gap_ones += int'(bus.mod_out);
      busy_lo  += int'(!bus.busy);
      dones    += int'(bus.done);
      if (k == second_k) begin
        bus.rx_eof = 1'b1;
        bus.fdt    = 16'(f + 77);
      end else begin
        bus.rx_eof = 1'b0;
      end
    end
    check({name, "_gap_mod"}, BC'(gap_ones), BC'(0));
    foreach (bits[j]) begin
      for (int c = 0; c < BC; c++) begin
        tick;
        obs[c]   = bus.mod_out;
        busy_lo += int'(!bus.busy);
        dones   += int'(bus.done);
      end
      check($sformatf("%s_bit%0d", name, j), obs, bit_wave(bits[j]));
    end
    for (int c = 0; c < BC; c++) begin
      tick;
      obs[c]   = bus.mod_out;
      busy_lo += int'(!bus.busy);
      if (bus.done) begin
        dones++;
        done_pos = c;
      end
    end
    check({name, "_eof_mod"}, obs, '0);
    check({name, "_done_cnt"}, BC'(dones), BC'(1));
    check({name, "_done_pos"}, BC'(done_pos), BC'(BC - 2));
    check({name, "_busy_lo"}, BC'(busy_lo), BC'(1));
    check({name, "_idle"}, BC'(bus.busy), BC'(0));
    check({name, "_empty"}, BC'(bus.fifo_empty), BC'(1));
  endtask

  initial begin
    logic [7:0] q[$];
    int         acc;
    bus.wr_data = '0; bus.wr_en = 1'b0; bus.abort = 1'b0; bus.rx_eof = 1'b0; bus.fdt = '0;

    #2 reset = 1'b1;
    #2;
    check("rst_mod", BC'(bus.mod_out), BC'(0));
    check("rst_busy", BC'(bus.busy), BC'(0));
    check("rst_done", BC'(bus.done), BC'(0));
    check("rst_empty", BC'(bus.fifo_empty), BC'(1));
    check("rst_full", BC'(bus.fifo_full), BC'(0));
    #8 reset = 1'b0;
    tick;

    // Empty FIFO: rx_eof must not start a frame.
    bus.rx_eof = 1'b1; bus.fdt = 16'd0;
    tick;
    bus.rx_eof = 1'b0;
    acc = 0;
    repeat (6) begin
      acc += int'(bus.busy) + int'(bus.mod_out);
      tick;
    end
    check("empty_eof_quiet", BC'(acc), BC'(0));

    q = '{8'h04, 8'h00};
    write_bytes(q);
    run_frame("atqa", q, 1172, 500);

    q = '{8'h01};
    write_bytes(q);
    run_frame("one", q, 0, -1);

    q = '{8'hFF};
    write_bytes(q);
    run_frame("ff", q, 3, -1);

    // FIFO boundary: 17 writes into a 16-deep buffer.
    q = {};
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'($urandom);
      if (i < DEPTH) q.push_back(bus.wr_data);
      tick;
      if (i == DEPTH - 2) check("full_at15", BC'(bus.fifo_full), BC'(0));
      if (i == DEPTH - 1) check("full_at16", BC'(bus.fifo_full), BC'(1));
    end
    bus.wr_en = 1'b0;
    check("full_after17", BC'(bus.fifo_full), BC'(1));
    run_frame("full16", q, 2, -1);

    for (int r = 0; r < 4; r++) begin
      int n, f, s;
      q = {};
      n = $urandom_range(3, 1);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      f = $urandom_range(300, 2);
      s = (r % 2 == 1) ? $urandom_range(f, 1) : -1;
      write_bytes(q);
      run_frame($sformatf("rnd%0d", r), q, f, s);
    end

    // Abort during byte 2 of 4, with a simultaneous write that must be discarded.
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_bytes(q);
    bus.rx_eof = 1'b1; bus.fdt = 16'd10;
    tick;
    bus.rx_eof = 1'b0;
    repeat (12 + (1 + BPB + 3) * BC + 20) tick;
    check("abort_pre_busy", BC'(bus.busy), BC'(1));
    bus.abort = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick;
    bus.abort = 1'b0; bus.wr_en = 1'b0;
    check("abort_mod", BC'(bus.mod_out), BC'(0));
    check("abort_busy", BC'(bus.busy), BC'(0));
    check("abort_empty", BC'(bus.fifo_empty), BC'(1));
    acc = 0;
    repeat (300) begin
      acc += int'(bus.done) + int'(bus.busy) + int'(bus.mod_out) + int'(!bus.fifo_empty);
      tick;
    end
    check("abort_quiet", BC'(acc), BC'(0));

    // Asynchronous reset in the middle of SOF clears FIFO contents too.
    q = '{8'h5A, 8'hC3};
    write_bytes(q);
    bus.rx_eof = 1'b1; bus.fdt = 16'd5;
    tick;
    bus.rx_eof = 1'b0;
    repeat (5 + 2 + 30) tick;
    check("sof_busy", BC'(bus.busy), BC'(1));
    #3 reset = 1'b1;
    #1;
    check("arst_mod", BC'(bus.mod_out), BC'(0));
    check("arst_busy", BC'(bus.busy), BC'(0));
    check("arst_done", BC'(bus.done), BC'(0));
    check("arst_empty", BC'(bus.fifo_empty), BC'(1));
    check("arst_full", BC'(bus.fifo_full), BC'(0));
    #2 reset = 1'b0;
    tick;
    bus.rx_eof = 1'b1; bus.fdt = 16'd0;
    tick;
    bus.rx_eof = 1'b0;
    acc = 0;
    repeat (6) begin
      acc += int'(bus.busy) + int'(bus.mod_out);
      tick;
    end
    check("arst_no_frame", BC'(acc), BC'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
